cm0_pmu_cdc_hs_recv: RTL



---
 rtl/cm0_pmu_cdc_hs_recv.sv | 99 +++++++++
 1 files changed

// File: rtl/cm0_pmu_cdc_hs_recv.sv
// Receive side of the PMU four-phase req/ack crossing: synchronises REQI, captures
// DATAI, offers it locally with a valid/accept handshake and returns ACKO from a flop.
//
// state | meaning
// IDLE  | no word held, waiting for the synchronised request
// HOLD  | word captured in DATAO, VALID high, waiting for ACCEPT
// ACK   | word consumed, ACKO high, waiting for the request to drop
module cm0_pmu_cdc_hs_recv #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          REGCLK,
    input  logic          REGRESETn,
    input  logic          REQI,
    input  logic [DW-1:0] DATAI,
    input  logic          ACCEPT,
    output logic          VALID,
    output logic [DW-1:0] DATAO,
    output logic          ACKO,
    output logic          PROTERR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   reqs;
    logic                   capture;
    logic                   proto_err;

    assign reqs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge REGCLK or negedge REGRESETn) begin
        if (!REGRESETn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], REQI};
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        proto_err = 1'b0;
        case (state)
            IDLE: begin
                if (reqs) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // a request withdrawn before consumption wins over a same-edge accept
                if (!reqs) begin
                    proto_err = 1'b1;
                    state_nxt = IDLE;
                end else if (ACCEPT) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!reqs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // VALID and ACKO are dedicated flops so the sender sees a glitch-free ACK
    always_ff @(posedge REGCLK or negedge REGRESETn) begin
        if (!REGRESETn) begin
            state   <= IDLE;
            VALID   <= 1'b0;
            ACKO    <= 1'b0;
            PROTERR <= 1'b0;
            DATAO   <= '0;
        end else begin
            state <= state_nxt;
            VALID <= (state_nxt == HOLD);
            ACKO  <= (state_nxt == ACK);
            if (proto_err) begin
                PROTERR <= 1'b1;
            end
            if (capture) begin
                DATAO <= DATAI;
            end
        end
    end

    accept_known : assert property (@(posedge REGCLK) disable iff (!REGRESETn)
        VALID |-> !$isunknown(ACCEPT));

endmodule
